// File: rtl/gate_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_share_arbiter: round-robin share of one registered AND unit      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gate_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_ready,
  output logic [15:0]            txn_count
);

  localparam int CW = ID_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     count_q, count_d;

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [CW-1:0]   cand;
  logic            can_accept;
  logic            accept;
  logic            drain;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    can_accept = (state_q == IDLE) || res_ready;
    accept     = rst_n && can_accept && win_found;
    drain      = (state_q == HOLD) && res_ready;

    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    count_d  = count_q;

    if (drain && count_q != 16'hFFFF) count_d = count_q + 16'd1;

    // A drain and an accept in the same cycle keep the unit in HOLD.
    if (accept) begin
      state_d  = HOLD;
      data_d   = req_a[win_idx*WIDTH +: WIDTH] & req_b[win_idx*WIDTH +: WIDTH];
      id_d     = win_idx;
      rr_ptr_d = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end else if (drain) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      count_q  <= count_d;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign txn_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_share_arbiter.sv
`default_nettype none
// Directed and random checks of gate_share_arbiter against a behavioural model.
module tb_gate_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_ready;
  logic [15:0]    txn_count;

  gate_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];

  // Reference model state
  int m_ptr = 0;
  bit m_hold = 0;
  int m_data = 0;
  int m_id = 0;
  int m_count = 0;

  logic [N-1:0] last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check before the edge, advance the model at the edge.
  task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic rn);
    int  win;
    bit  found;
    int  exp_ready;
    bit  acc, drn;
    @(negedge clk);
    req_valid = v;
    res_ready = rdy;
    rst_n     = rn;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_op[i];
      req_b[i*W +: W] = b_op[i];
    end
    #1;
    found = 0;
    win = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!found && v[i]) begin found = 1; win = i; end
    end
    acc = rn && (!m_hold || rdy) && found;
    drn = m_hold && rdy;
    exp_ready = acc ? (1 << win) : 0;
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("res_valid", 32'(res_valid), 32'(m_hold));
    if (m_hold) begin
      chk("res_data", 32'(res_data), 32'(m_data));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    chk("txn_count", 32'(txn_count), 32'(m_count));
    @(posedge clk);
    if (!rn) begin
      m_ptr = 0; m_hold = 0; m_data = 0; m_id = 0; m_count = 0;
    end else begin
      if (drn && m_count < 65535) m_count++;
      if (acc) begin
        m_hold = 1;
        m_data = int'(a_op[win] & b_op[win]);
        m_id   = win;
        m_ptr  = (win + 1) % N;
      end else if (drn) begin
        m_hold = 0;
      end
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_op[i] = W'($urandom);
      b_op[i] = W'($urandom);
    end
  endtask

  initial begin
    logic [N-1:0] fair_exp [5];
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0; req_a = '0; req_b = '0;
    rand_ops();

    // Reset with everything requesting: no grants leak out
    cyc(4'hF, 1'b1, 1'b0);
    cyc(4'hF, 1'b1, 1'b0);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", 32'(res_data), 32'h0);
    chk("rst_txn", 32'(txn_count), 32'h0);

    // Single request
    a_op[2] = 8'hF0; b_op[2] = 8'h3C;
    cyc(4'b0100, 1'b0, 1'b1);
    chk("single_grant", 32'(last_ready), 32'h4);
    #1;
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_data", 32'(res_data), 32'h30);
    chk("single_id", 32'(res_id), 32'h2);
    cyc(4'b0000, 1'b1, 1'b1);

    // Fairness from a freshly reset pointer
    cyc(4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cyc(4'hF, 1'b1, 1'b1);
      chk("fair_grant", 32'(last_ready), 32'(fair_exp[i]));
    end

    // Backpressure then simultaneous drain and accept
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cyc(4'hF, 1'b0, 1'b1);
    end
    cyc(4'hF, 1'b1, 1'b1);
    chk("bp_release_grant", 32'(last_ready != 0), 32'h1);

    // Reset while holding an undelivered result
    cyc(4'hF, 1'b0, 1'b1);
    cyc(4'hF, 1'b0, 1'b0);
    #1;
    chk("midrst_valid", 32'(res_valid), 32'h0);
    chk("midrst_txn", 32'(txn_count), 32'h0);
    cyc(4'hF, 1'b1, 1'b1);
    chk("midrst_grant", 32'(last_ready), 32'h1);

    // Withdrawn request: pointer is 1, requester 1 leaves before acceptance
    cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b1000, 1'b1, 1'b1);
    chk("withdraw_grant", 32'(last_ready), 32'h8);
    cyc(4'hF, 1'b1, 1'b1);
    chk("withdraw_ptr_wrap", 32'(last_ready), 32'h1);

    // Drain to idle, then res_ready in idle has no effect
    cyc(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'h0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cyc(N'($urandom), 1'($urandom), ($urandom_range(0, 49) != 0));
    end

    // Saturation of the handshake counter
    cyc(4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) cyc(4'hF, 1'b1, 1'b1);
    #1;
    chk("sat_txn", 32'(txn_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_share_arbiter.md
GATE_SHARE_ARBITER -- requirements
Module: gate_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the bitwise-AND unit (legal range 2..8).
REQ-002 Parameter WIDTH, default 8: operand and result width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port req_valid, input, N_REQ: bit i set means requester i presents an operation.
REQ-006 Port req_a, input, N_REQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port req_b, input, N_REQ*WIDTH: operand B; same packing as req_a.
REQ-008 Port req_ready, output, N_REQ: one-hot or zero; bit i set means requester i is accepted this cycle.
REQ-009 Port res_valid, output, 1: result register holds an undelivered result.
REQ-010 Port res_data, output, WIDTH: req_a AND req_b of the accepted requester.
REQ-011 Port res_id, output, clog2(N_REQ): index of the requester that owns res_data.
REQ-012 Port res_ready, input, 1: consumer accepts the result when res_valid and res_ready are both 1.
REQ-013 Port txn_count, output, 16: number of completed result handshakes.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE (no held result) and HOLD (result held); res_valid SHALL be 1 exactly in HOLD.
REQ-015 can_accept SHALL be defined as (state==IDLE) or (state==HOLD and res_ready==1).
REQ-016 When can_accept=1 and req_valid!=0, exactly one req_ready bit SHALL be 1: the winner, combinationally in the same cycle.
REQ-017 When can_accept=0 or req_valid==0, req_ready SHALL be all zero.
REQ-018 Winner selection SHALL be round-robin: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-019 On an accept edge, rr_ptr SHALL become (winner+1) mod N_REQ; otherwise rr_ptr SHALL hold.
REQ-020 On an accept edge, res_data SHALL load req_a[winner] & req_b[winner], res_id SHALL load winner, and state SHALL go to HOLD.
REQ-021 Latency: the result SHALL be visible on res_valid/res_data exactly 1 cycle after the accept edge.
REQ-022 In HOLD with res_ready=0, res_valid, res_data and res_id SHALL be held stable, and no request SHALL be accepted.
REQ-023 In HOLD with res_ready=1 and no req_valid, state SHALL return to IDLE.
REQ-024 In HOLD with res_ready=1 and any req_valid (simultaneous drain and accept), state SHALL stay HOLD and the new result SHALL be loaded, giving throughput of 1 result per cycle.
REQ-025 Requesters SHALL hold req_valid and operands stable until their req_ready; the arbiter SHALL NOT register operands of unaccepted requesters.
REQ-026 A requester dropping req_valid before acceptance SHALL simply be skipped, with no error and no pointer change.
REQ-027 txn_count SHALL increment on every cycle with res_valid & res_ready, and SHALL saturate at 16'hFFFF (no wrap).
REQ-028 res_ready while in IDLE SHALL be ignored: no count change and no state change.

Reset
REQ-029 On a clk edge with rst_n=0: state=IDLE, res_valid=0, res_data=0, res_id=0, rr_ptr=0, txn_count=0.
REQ-030 While rst_n=0, req_ready SHALL be all zero.
REQ-031 Reset asserted in HOLD SHALL discard the held result without a handshake and without a txn_count increment.
REQ-032 Reset SHALL take priority over every simultaneous accept or drain.

Verification
REQ-033 Single request: N_REQ=4, req_valid=4'b0100, a=8'hF0, b=8'h3C -> req_ready=4'b0100 same cycle; the next cycle res_valid=1, res_data=8'h30, res_id=2.
REQ-034 Fairness: all four valid and res_ready=1 held -> grants in order 0,1,2,3,0 on consecutive cycles; txn_count increases by 1 per cycle after the first.
REQ-035 Backpressure: res_ready=0 for 5 cycles with requests pending -> req_ready=0 throughout, res_data/res_id stable; on release, drain and accept in the same cycle.
REQ-036 Saturation: drive 65,537 handshakes (or force the count near its limit) -> txn_count stays 16'hFFFF.
REQ-037 Mid-operation reset: rst_n=0 while HOLD with res_ready=0 -> the next cycle has res_valid=0, txn_count=0, and the next grant goes to requester 0 when all requesters are valid.
REQ-038 Withdrawn request: rr_ptr=1, req_valid=4'b0010 dropped to 4'b1000 before acceptance -> requester 3 is granted and rr_ptr becomes 0.
